// File: rtl/tmul_dot_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tmul_dot_seq
// Description : Operand sequencer for the TMUL FMA stage. Runs one K-length
//               dot product acc = c_init + sum(a[i]*b[i]). Each product goes
//               through the external FMA with the running accumulator as the
//               addend. The FMA result is captured LAT edges after issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tmul_dot_seq #(
   parameter int K_MAX = 64,  // longest dot product accepted
   parameter int LAT   = 1,   // FMA latency in clk edges, must be >= 1
   parameter int CW    = 7    // counter width, 2**CW > K_MAX
) (
   input  logic          clk,
   input  logic          rst,        // asynchronous, active-low
   input  logic          clr,        // synchronous abort
   input  logic          start,
   input  logic [CW-1:0] k_len,
   input  logic [63:0]   c_init,
   output logic          busy,
   input  logic          in_valid,
   input  logic [31:0]   in_a,
   input  logic [31:0]   in_b,
   output logic          in_ready,
   output logic [31:0]   fma_a,
   output logic [31:0]   fma_b,
   output logic [63:0]   fma_c,
   input  logic [63:0]   fma_out,
   output logic          res_valid,
   output logic [63:0]   res_data,
   input  logic          res_ready
);

   // The wait counter must be able to hold the value LAT
   localparam int            WW      = (LAT < 2) ? 1 : $clog2(LAT + 1);
   localparam logic [CW-1:0] K_MAX_C = CW'(K_MAX);
   localparam logic [WW-1:0] LAT_C   = WW'(LAT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [63:0]   acc;
   logic [CW-1:0] cnt;
   logic [WW-1:0] wait_cnt;
   logic [CW-1:0] k_eff;
   logic          issue_fire;
   logic          capture;

   // Requested lengths above K_MAX are clamped
   assign k_eff      = (k_len > K_MAX_C) ? K_MAX_C : k_len;
   // An operand pair is handed to the FMA on this edge
   assign issue_fire = (state == S_ISSUE) && in_valid;
   // The FMA result for the pair in flight is usable on this edge
   assign capture    = (state == S_WAIT) && (wait_cnt == WW'(1));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; clr overrides every transition
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = (k_len == '0) ? S_OUT : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (in_valid) begin
               next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (capture) begin
               next_state = (cnt == CW'(1)) ? S_OUT : S_ISSUE;
            end
         end
         S_OUT: begin
            if (res_ready) begin
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
      if (clr) begin
         next_state = S_IDLE;
      end
   end

   // Accumulator, element counter and FMA latency counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc      <= '0;
         cnt      <= '0;
         wait_cnt <= '0;
      end else if (clr) begin
         acc      <= '0;
         cnt      <= '0;
         wait_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc <= c_init;
                  cnt <= k_eff;
               end
            end
            S_ISSUE: begin
               if (issue_fire) begin
                  wait_cnt <= LAT_C;
               end
            end
            S_WAIT: begin
               if (capture) begin
                  acc      <= fma_out;
                  cnt      <= cnt - CW'(1);
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt - WW'(1);
               end
            end
            default: begin
               acc <= acc;
            end
         endcase
      end
   end

   // Outputs decoded from state; in_valid gates the operand bus only
   always_comb begin
      busy      = 1'b0;
      in_ready  = 1'b0;
      fma_a     = '0;
      fma_b     = '0;
      fma_c     = '0;
      res_valid = 1'b0;
      res_data  = '0;
      case (state)
         S_ISSUE: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            fma_c    = acc;
            if (in_valid) begin
               fma_a = in_a;
               fma_b = in_b;
            end
         end
         S_WAIT: begin
            busy  = 1'b1;
            fma_c = acc;
         end
         S_OUT: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            res_data  = acc;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_tmul_dot_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tmul_dot_seq
// Description : Scoreboard bench for tmul_dot_seq. Two instances: LAT=1 and
//               LAT=4, each with a behavioural FMA pipeline. Directed runs
//               push hand-computed results; a monitor pops and compares on
//               every result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmul_dot_seq;

   localparam int CW    = 7;
   localparam int K_MAX = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   logic          start     [2];
   logic          clr       [2];
   logic [CW-1:0] k_len     [2];
   logic [63:0]   c_init    [2];
   logic          busy      [2];
   logic          in_valid  [2];
   logic [31:0]   in_a      [2];
   logic [31:0]   in_b      [2];
   logic          in_ready  [2];
   logic [31:0]   fma_a     [2];
   logic [31:0]   fma_b     [2];
   logic [63:0]   fma_c     [2];
   logic [63:0]   fma_out   [2];
   logic          res_valid [2];
   logic [63:0]   res_data  [2];
   logic          res_ready [2];

   logic [31:0] va [64];
   logic [31:0] vb [64];
   logic [63:0] q0 [$];
   logic [63:0] q1 [$];

   always #5 clk = ~clk;

   // Free-running edge counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   generate
      for (genvar g = 0; g < 2; g++) begin : g_dut
         localparam int L = (g == 0) ? 1 : 4;
         logic [63:0] pipe [L];

         tmul_dot_seq #(.K_MAX(K_MAX), .LAT(L), .CW(CW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr[g]),
            .start     (start[g]),
            .k_len     (k_len[g]),
            .c_init    (c_init[g]),
            .busy      (busy[g]),
            .in_valid  (in_valid[g]),
            .in_a      (in_a[g]),
            .in_b      (in_b[g]),
            .in_ready  (in_ready[g]),
            .fma_a     (fma_a[g]),
            .fma_b     (fma_b[g]),
            .fma_c     (fma_c[g]),
            .fma_out   (fma_out[g]),
            .res_valid (res_valid[g]),
            .res_data  (res_data[g]),
            .res_ready (res_ready[g])
         );

         // Behavioural FMA: a*b+c mod 2**64, L pipeline stages
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < L; i++) pipe[i] <= '0;
            end else begin
               pipe[0] <= {32'd0, fma_a[g]} * {32'd0, fma_b[g]} + fma_c[g];
               for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
            end
         end
         assign fma_out[g] = pipe[L-1];
      end
   endgenerate

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   task automatic check(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
      end
   endtask

   task automatic present(input int d, input int i);
      in_valid[d] = 1'b1;
      in_a[d]     = va[i];
      in_b[d]     = vb[i];
   endtask

   // Monitor: compare every result handshake against the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            if (res_valid[d] && res_ready[d]) begin
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  total++;
                  bad++;
                  $display("FAIL res_unexpected dut%0d: got result 0x%0h expected none", d, res_data[d]);
               end else if (d == 0) begin
                  check(d, "res_data", res_data[d], q0.pop_front());
               end else begin
                  check(d, "res_data", res_data[d], q1.pop_front());
               end
            end
         end
      end
   end

   // One complete dot product: pairs come from va/vb, gap idles in_valid
   // between pairs, hold delays res_ready, exp_lat checks start-to-result edges
   task automatic run_dot(input int d, input logic [63:0] c, input int k, input logic [63:0] exp,
                          input int gap, input int hold, input int exp_lat, input bit spurious);
      int n;
      int lows;
      int w;
      int cyc0;
      n = (k > K_MAX) ? K_MAX : k;
      if (d == 0) q0.push_back(exp); else q1.push_back(exp);
      res_ready[d] = (hold == 0);
      start[d]  = 1'b1;
      k_len[d]  = CW'(k);
      c_init[d] = c;
      @(posedge clk); #1;
      start[d] = 1'b0;
      cyc0 = cyc;
      if (n > 0) present(d, 0);
      for (int i = 0; i < n; i++) begin
         lows = 0;
         @(negedge clk);
         while (!in_ready[d] && lows < 100) begin
            lows++;
            @(negedge clk);
         end
         if (!in_ready[d]) begin
            check(d, "in_ready_timeout", in_ready[d], 1);
            break;
         end
         if (i > 0 && gap == 0) check(d, "in_ready_low_cycles", lows, lat_of(d));
         if (spurious && i == 0) begin
            start[d]  = 1'b1;
            k_len[d]  = '0;
            c_init[d] = 64'hBAD;
         end
         @(posedge clk); #1;
         start[d]    = 1'b0;
         in_valid[d] = 1'b0;
         if (i < n - 1) begin
            if (gap > 0) begin
               repeat (gap) @(posedge clk);
               #1;
            end
            present(d, i + 1);
         end
      end
      w = 0;
      while (!res_valid[d] && w < 400) begin
         @(negedge clk);
         w++;
      end
      check(d, "res_valid_seen", res_valid[d], 1);
      if (exp_lat > 0) check(d, "res_latency", cyc - cyc0 + 1, exp_lat);
      check(d, "in_ready_in_out", in_ready[d], 0);
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            check(d, "hold_valid", res_valid[d], 1);
            check(d, "hold_data", res_data[d], exp);
         end
         @(posedge clk); #1;
         res_ready[d] = 1'b1;
      end
      w = 0;
      while (busy[d] && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      check(d, "busy_clear", busy[d], 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 400000ns");
      $fatal(1);
   end

   initial begin
      int w;
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0; clr[d] = 1'b0; k_len[d] = '0; c_init[d] = '0;
         in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0; res_ready[d] = 1'b0;
      end
      for (int i = 0; i < 64; i++) begin
         va[i] = 32'd1;
         vb[i] = 32'd1;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check(d, "rst_busy", busy[d], 0);
         check(d, "rst_in_ready", in_ready[d], 0);
         check(d, "rst_res_valid", res_valid[d], 0);
         check(d, "rst_fma_a", fma_a[d], 0);
         check(d, "rst_fma_b", fma_b[d], 0);
         check(d, "rst_fma_c", fma_c[d], 0);
         check(d, "rst_res_data", res_data[d], 0);
      end
      rst = 1'b1;
      @(posedge clk); #1;

      // T1: 5 + 2*3 + 4*5 + 6*7 = 73; result on the 7th edge counting the start edge
      va[0] = 32'd2; vb[0] = 32'd3;
      va[1] = 32'd4; vb[1] = 32'd5;
      va[2] = 32'd6; vb[2] = 32'd7;
      run_dot(0, 64'd5, 3, 64'd73, 0, 0, 7, 1'b0);

      // T2: zero length returns c_init on the next cycle
      run_dot(0, 64'hDEAD, 0, 64'hDEAD, 0, 0, 1, 1'b0);

      // T3: accumulator wraps modulo 2**64
      va[0] = 32'd1; vb[0] = 32'd1;
      run_dot(0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0, 0, 0, 0, 1'b0);

      // T4: LAT=4, two max-value products
      va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF;
      va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF;
      run_dot(1, 64'd0, 2, 64'hFFFF_FFFC_0000_0002, 0, 0, 0, 1'b0);

      // T5: in_valid gaps and result backpressure; 1+100+60+63 = 224
      va[0] = 32'd10; vb[0] = 32'd10;
      va[1] = 32'd20; vb[1] = 32'd3;
      va[2] = 32'd7;  vb[2] = 32'd9;
      run_dot(0, 64'd1, 3, 64'd224, 3, 10, 0, 1'b0);
      // 100 + 25 + 36 = 161
      va[0] = 32'd5; vb[0] = 32'd5;
      va[1] = 32'd6; vb[1] = 32'd6;
      run_dot(1, 64'd100, 2, 64'd161, 2, 10, 0, 1'b0);

      // T6a: clr while waiting on the FMA drops the run
      res_ready[1] = 1'b1;
      start[1] = 1'b1; k_len[1] = CW'(2); c_init[1] = 64'd7;
      @(posedge clk); #1;
      start[1] = 1'b0;
      in_valid[1] = 1'b1; in_a[1] = 32'd3; in_b[1] = 32'd3;
      w = 0;
      @(negedge clk);
      while (!in_ready[1] && w < 20) begin
         w++;
         @(negedge clk);
      end
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      @(posedge clk); #1;
      clr[1] = 1'b1;
      @(posedge clk); #1;
      clr[1] = 1'b0;
      check(1, "clr_busy", busy[1], 0);
      check(1, "clr_res_valid", res_valid[1], 0);
      check(1, "clr_in_ready", in_ready[1], 0);
      check(1, "clr_fma_c", fma_c[1], 0);
      repeat (8) @(posedge clk);
      #1;
      check(1, "clr_stays_idle", busy[1], 0);
      // Fresh run after clr: 3 + 9 + 16 = 28
      va[0] = 32'd3; vb[0] = 32'd3;
      va[1] = 32'd4; vb[1] = 32'd4;
      run_dot(1, 64'd3, 2, 64'd28, 0, 0, 0, 1'b0);

      // T6b: asynchronous reset pulse while waiting for operands
      res_ready[0] = 1'b1;
      start[0] = 1'b1; k_len[0] = CW'(2); c_init[0] = 64'd9;
      @(posedge clk); #1;
      start[0] = 1'b0;
      #1 rst = 1'b0;
      #1;
      check(0, "arst_busy", busy[0], 0);
      check(0, "arst_in_ready", in_ready[0], 0);
      check(0, "arst_fma_c", fma_c[0], 0);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      // Fresh run with a start pulse while busy: 9 + 56 + 2 = 67
      va[0] = 32'd7; vb[0] = 32'd8;
      va[1] = 32'd1; vb[1] = 32'd2;
      run_dot(0, 64'd9, 2, 64'd67, 0, 0, 0, 1'b1);

      // Length above K_MAX clamps to 64 unit products
      for (int i = 0; i < 64; i++) begin
         va[i] = 32'd1;
         vb[i] = 32'd1;
      end
      run_dot(0, 64'd0, 100, 64'd64, 0, 0, 0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check(0, "scoreboard_drained", q0.size(), 0);
      check(1, "scoreboard_drained", q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
